bus_dispatch: RTL and testbench

Stream distributor for the HOG datapath: takes one BUS_WIDTH valid/ready stream from the Avalon bus bridge and deals it out, in bursts of up to BURST_LEN beats, to LEVELS downstream consumers (per-level deserializers) in round-robin order. It is the receive-side counterpart of the many-to-one bus arbiter. The output is one registered pipeline stage, so every consumer sees registered valid and data.

---
 rtl/bus_dispatch_pkg.sv | 23 ++
 rtl/rr_pick.sv | 34 +++
 rtl/bus_dispatch.sv | 145 ++++++++++++++
 tb/tb_bus_dispatch.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dispatch_pkg.sv
// Shared types and constants for the bus dispatcher and its arbiter sibling.
package bus_dispatch_pkg;

  localparam int DEFAULT_BUS_WIDTH = 128;
  localparam int DEFAULT_LEVELS    = 7;
  localparam int DEFAULT_BURST_LEN = 9;

  typedef enum logic {
    S_SEEK  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // Consumer index width; at least one bit even for tiny LEVELS.
  function automatic int ptr_width(input int levels);
    return (levels > 2) ? $clog2(levels) : 1;
  endfunction

  // Beat counter must be able to hold the value BURST_LEN itself.
  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-one finder: returns the first index at or after i_start
// whose request bit is set. Purely combinational.
module rr_pick #(
  parameter int LEVELS = 7,
  parameter int PW     = 3
) (
  input  logic [LEVELS-1:0] i_req,
  input  logic [PW-1:0]     i_start,
  output logic [PW-1:0]     o_idx,
  output logic              o_found
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int          w_j;
    logic [PW-1:0] w_cand;
    o_idx   = i_start;
    o_found = 1'b0;
    w_j     = 0;
    w_cand  = '0;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      w_j = int'(i_start) + k;
      if (w_j >= LEVELS) begin
        w_j = w_j - LEVELS;
      end
      w_cand = PW'(w_j);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_dispatch.sv
// Round-robin stream distributor: deals bursts of up to BURST_LEN beats from
// one valid/ready input to LEVELS consumers through a single registered stage.
// Optional macro BUS_DISPATCH_SKIP_EN: seek jumps straight to the next ready
// consumer in one cycle instead of stepping one index per cycle.
module bus_dispatch
  import bus_dispatch_pkg::*;
#(
  parameter int BUS_WIDTH    = DEFAULT_BUS_WIDTH,
  parameter int LEVELS       = DEFAULT_LEVELS,
  parameter int BURST_LEN    = DEFAULT_BURST_LEN,
  parameter int OUTPUT_WIDTH = BUS_WIDTH * LEVELS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [BUS_WIDTH-1:0]    in_stream,
  output logic                    in_ready,
  input  logic [LEVELS-1:0]       out_ready,
  output logic [LEVELS-1:0]       out_valid,
  output logic [OUTPUT_WIDTH-1:0] out_stream
);

  localparam int PW = ptr_width(LEVELS);
  localparam int CW = cnt_width(BURST_LEN);
  localparam logic [PW-1:0] LAST_IDX  = PW'(LEVELS - 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [CW-1:0]        r_beat_cnt;
  logic                 r_buf_valid;
  logic [BUS_WIDTH-1:0] r_buf_data;
  logic [PW-1:0]        r_buf_dest;

  state_t               w_state_nxt;
  logic [PW-1:0]        w_ptr_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [CW-1:0]        w_cnt_inc;
  logic                 w_buf_dest_ready;
  logic                 w_accept;

  // Explicit compare against the last index: LEVELS need not be a power of two.
  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign w_buf_dest_ready = out_ready[r_buf_dest];
  assign w_cnt_inc        = r_beat_cnt + 1'b1;
  assign in_ready         = (r_state == S_GRANT)
                          && (!r_buf_valid || w_buf_dest_ready)
                          && (r_beat_cnt < BURST_MAX);
  assign w_accept         = in_valid && in_ready;

`ifdef BUS_DISPATCH_SKIP_EN
  logic [PW-1:0] w_pick_idx;
  logic          w_pick_found;

  rr_pick #(
    .LEVELS (LEVELS),
    .PW     (PW)
  ) u_rr_pick (
    .i_req   (out_ready),
    .i_start (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );
`endif

  // Next-state logic: seek for a ready consumer, then stream the burst.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      S_SEEK: begin
`ifdef BUS_DISPATCH_SKIP_EN
        if (in_valid && w_pick_found) begin
          w_ptr_nxt   = w_pick_idx;
          w_state_nxt = S_GRANT;
          w_cnt_nxt   = '0;
        end
`else
        if (in_valid && out_ready[r_ptr]) begin
          w_state_nxt = S_GRANT;
          w_cnt_nxt   = '0;
        end else if (in_valid) begin
          w_ptr_nxt = f_wrap(r_ptr);
        end
`endif
      end
      S_GRANT: begin
        // An idle input ends the grant; a stalled consumer never does.
        if (!in_valid) begin
          w_state_nxt = S_SEEK;
          w_ptr_nxt   = f_wrap(r_ptr);
        end else if (w_accept) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == BURST_MAX) begin
            w_state_nxt = S_SEEK;
            w_ptr_nxt   = f_wrap(r_ptr);
          end
        end
      end
      default: begin
        w_state_nxt = S_SEEK;
      end
    endcase
  end

  // FSM, pointer and burst counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_SEEK;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  // Output buffer: load on accept (drain+load is bubble-free), else drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
      r_buf_dest  <= '0;
    end else if (w_accept) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= in_stream;
      r_buf_dest  <= r_ptr;
    end else if (r_buf_valid && w_buf_dest_ready) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Fan the buffer out to its destination slice; other slices stay zero.
  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_out
    assign out_valid[gi] = r_buf_valid && (r_buf_dest == PW'(gi));
    assign out_stream[gi*BUS_WIDTH +: BUS_WIDTH] =
      out_valid[gi] ? r_buf_data : '0;
  end

endmodule

// File: tb/tb_bus_dispatch.sv
// Scenario bench for bus_dispatch: expected beats are queued on acceptance
// and popped when the DUT delivers them to a consumer.
module tb_bus_dispatch;

  localparam int BW = 128;
  localparam int LV = 7;
  localparam int BL = 9;
  localparam int OW = BW * LV;

  typedef struct {
    int          dest;
    logic [BW-1:0] data;
    int          cyc;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [BW-1:0] in_stream;
  logic          in_ready;
  logic [LV-1:0] out_ready;
  logic [LV-1:0] out_valid;
  logic [OW-1:0] out_stream;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  beat_t exp_q[$];

  bus_dispatch #(
    .BUS_WIDTH (BW),
    .LEVELS    (LV),
    .BURST_LEN (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_stream  (in_stream),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_stream (out_stream)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: sample at negedge, push accepted beats, pop delivered ones.
  task automatic step(input int exp_dest, output logic acc, output logic rdy,
                      output logic dlv, output logic [LV-1:0] ov,
                      output logic [OW-1:0] os, output beat_t got,
                      output beat_t want);
    beat_t         b;
    logic [LV-1:0] m;
    @(negedge clk);
    rdy  = in_ready;
    ov   = out_valid;
    os   = out_stream;
    acc  = in_valid && in_ready;
    dlv  = |(out_valid & out_ready);
    got  = '{dest: -1, data: '0, cyc: cyc};
    want = '{dest: -2, data: '0, cyc: -1};
    for (int i = 0; i < LV; i++) begin
      m = LV'(1) << i;
      if ((out_valid & m) != '0) begin
        got.dest = i;
        got.data = BW'(out_stream >> (i * BW));
      end
    end
    if (acc) begin
      b.dest = exp_dest;
      b.data = in_stream;
      b.cyc  = cyc;
      exp_q.push_back(b);
    end
    if (dlv) begin
      if (exp_q.size() > 0) want = exp_q.pop_front();
      $display("beat cyc=%0d dest=%0d data=%0d", cyc, got.dest, got.data);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_stream = '0;
    out_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic acc, rdy, dlv; logic [LV-1:0] ov; logic [OW-1:0] os;
    beat_t got, want;
    int k;
    do_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== '0 || out_stream !== '0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b out_valid=%b stream_nonzero=%b want 0/0/0",
               in_ready, out_valid, |out_stream);
    end
    @(posedge clk);
    #1;
    k = 0;
    for (int n = 0; n < 20 && k < 4; n++) begin
      in_valid  = 1'b1;
      in_stream = BW'(50 + k);
      step(0, acc, rdy, dlv, ov, os, got, want);
      if (acc) k++;
    end
    checks++;
    if (k != 4 || out_valid === '0) begin
      failures++;
      $display("FAIL reset_preburst accepted=%0d out_valid=%b want 4 beats and valid", k, out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== '0 || out_stream !== '0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_async out_valid=%b stream_nonzero=%b in_ready=%b want 0/0/0",
               out_valid, |out_stream, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    k = 0;
    for (int n = 0; n < 10 && k == 0; n++) begin
      in_valid  = 1'b1;
      in_stream = BW'(200);
      step(0, acc, rdy, dlv, ov, os, got, want);
      if (acc) in_valid = 1'b0;
      if (dlv) begin
        k = 1;
        checks++;
        if (got.dest !== 0 || got.data !== BW'(200)) begin
          failures++;
          $display("FAIL reset_first_beat dest=%0d data=%0d want dest=0 data=200",
                   got.dest, got.data);
        end
      end
    end
    in_valid = 1'b0;
    if (k == 0) begin
      failures++;
      $display("FAIL reset_first_beat timeout no delivery want dest=0");
    end
  endtask

  task automatic test_round_robin();
    logic acc, rdy, dlv; logic [LV-1:0] ov; logic [OW-1:0] os;
    beat_t got, want;
    int k, nd, gap;
    int acc_cyc[20];
    do_reset();
    k  = 0;
    nd = 0;
    for (int n = 0; n < 60 && nd < 20; n++) begin
      in_valid  = (k < 20);
      in_stream = BW'(k);
      step(k / BL, acc, rdy, dlv, ov, os, got, want);
      if (acc) begin
        acc_cyc[k] = cyc - 1;
        k++;
      end
      if (dlv) begin
        nd++;
        checks++;
        if (got.dest !== want.dest || got.data !== want.data || got.cyc !== want.cyc + 1) begin
          failures++;
          $display("FAIL rr_beat dest=%0d data=%0d cyc=%0d want dest=%0d data=%0d cyc=%0d",
                   got.dest, got.data, got.cyc, want.dest, want.data, want.cyc + 1);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nd != 20) begin
      failures++;
      $display("FAIL rr_count delivered=%0d want 20", nd);
    end else begin
      for (int i = 1; i < 20; i++) begin
        gap = (i == 9 || i == 18) ? 2 : 1;
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != gap) begin
          failures++;
          $display("FAIL rr_accept_gap beat=%0d gap=%0d want %0d",
                   i, acc_cyc[i] - acc_cyc[i-1], gap);
        end
      end
    end
  endtask

  task automatic test_unready();
    logic acc, rdy, dlv; logic [LV-1:0] ov; logic [OW-1:0] os;
    beat_t got, want;
    int k, nd, seek, seek_want;
`ifdef BUS_DISPATCH_SKIP_EN
    seek_want = 1;
`else
    seek_want = 2;
`endif
    do_reset();
    out_ready = 7'b1111110;
    k    = 0;
    nd   = 0;
    seek = 0;
    for (int n = 0; n < 60 && nd < 10; n++) begin
      in_valid  = (k < 10);
      in_stream = BW'(300 + k);
      step((k < BL) ? 1 : 2, acc, rdy, dlv, ov, os, got, want);
      if (acc) k++;
      else if (k == 0) seek++;
      if (dlv) begin
        nd++;
        checks++;
        if (got.dest !== want.dest || got.data !== want.data) begin
          failures++;
          $display("FAIL unready_beat dest=%0d data=%0d want dest=%0d data=%0d",
                   got.dest, got.data, want.dest, want.data);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (seek != seek_want || nd != 10) begin
      failures++;
      $display("FAIL unready_seek seek_cycles=%0d delivered=%0d want %0d and 10",
               seek, nd, seek_want);
    end
  endtask

  task automatic test_backpressure();
    logic acc, rdy, dlv; logic [LV-1:0] ov; logic [OW-1:0] os;
    beat_t got, want;
    logic [BW-1:0] s1;
    int k, nd, n1, stall;
    do_reset();
    k = 0; nd = 0; n1 = 0; stall = 0;
    for (int n = 0; n < 80 && nd < 19; n++) begin
      out_ready = (stall > 0) ? 7'b1111101 : 7'b1111111;
      in_valid  = (k < 19);
      in_stream = BW'(k);
      step(k / BL, acc, rdy, dlv, ov, os, got, want);
      if (stall > 0) begin
        s1 = BW'(os >> BW);
        checks++;
        if (rdy !== 1'b0 || ov !== 7'b0000010 || s1 !== BW'(13)) begin
          failures++;
          $display("FAIL stall_hold in_ready=%b out_valid=%b slice1=%0d want 0/0000010/13",
                   rdy, ov, s1);
        end
        stall--;
      end
      if (acc) begin
        if (k == 13) stall = 3;
        k++;
      end
      if (dlv) begin
        nd++;
        if (got.dest == 1) n1++;
        checks++;
        if (got.dest !== want.dest || got.data !== want.data) begin
          failures++;
          $display("FAIL stall_beat dest=%0d data=%0d want dest=%0d data=%0d",
                   got.dest, got.data, want.dest, want.data);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = '1;
    checks++;
    if (n1 != BL || nd != 19) begin
      failures++;
      $display("FAIL stall_burst_len consumer1=%0d delivered=%0d want 9 and 19", n1, nd);
    end
  endtask

  task automatic test_early_idle();
    logic acc, rdy, dlv; logic [LV-1:0] ov; logic [OW-1:0] os;
    beat_t got, want;
    int k, nd, idle;
    do_reset();
    k = 0; nd = 0; idle = 0;
    for (int n = 0; n < 40 && nd < 6; n++) begin
      in_valid  = (k == 3 && idle < 3) ? 1'b0 : (k < 6);
      in_stream = BW'(400 + k);
      step((k < 3) ? 0 : 1, acc, rdy, dlv, ov, os, got, want);
      if (k == 3 && idle < 3) begin
        if (idle >= 1) begin
          checks++;
          if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL idle_grant_end in_ready=%b want 0", rdy);
          end
        end
        idle++;
      end
      if (acc) k++;
      if (dlv) begin
        nd++;
        checks++;
        if (got.dest !== want.dest || got.data !== want.data) begin
          failures++;
          $display("FAIL idle_beat dest=%0d data=%0d want dest=%0d data=%0d",
                   got.dest, got.data, want.dest, want.data);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nd != 6) begin
      failures++;
      $display("FAIL idle_count delivered=%0d want 6", nd);
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_stream = '0;
    out_ready = '1;
    test_reset();
    test_round_robin();
    test_unready();
    test_backpressure();
    test_early_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
